// File: rtl/bfp16_pkg.sv
// -----------------------------------------------------------------------------
// bfp16_pkg
// Shared BFP16 (bfloat16) type and constants for the multiplier/arbiter slice.
//   bfp16_t        : packed {sign, exp[7:0], frac[6:0]}
//   BFP16_EXP_BIAS : exponent bias (127)
//   BFP16_EXP_MAX  : all-ones exponent marking Inf/NaN (255)
//   BFP16_ZERO     : positive zero encoding
// -----------------------------------------------------------------------------
package bfp16_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bfp16_t;

    localparam int          BFP16_EXP_BIAS = 127;
    localparam logic [7:0]  BFP16_EXP_MAX  = 8'd255;
    localparam logic [15:0] BFP16_ZERO     = 16'h0000;

endpackage

// File: rtl/bfp16_mul_arb_if.sv
// -----------------------------------------------------------------------------
// bfp16_mul_arb_if
// Request/response bus of the shared BFP16 multiplier.
//   req_valid/req_ready : per-requester handshake (NREQ bits)
//   req_a/req_b         : per-requester BFP16 operands (NREQ x 16)
//   rsp_valid/rsp_ready : product handshake
//   rsp_id              : requester index owning rsp_data
//   rsp_data            : BFP16 product
// Modports: master = requesters + consumer, slave = multiplier/arbiter.
// -----------------------------------------------------------------------------
interface bfp16_mul_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][15:0] req_a;
    logic [NREQ-1:0][15:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [15:0]           rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/bfp16_mul.sv
// -----------------------------------------------------------------------------
// bfp16_mul
// Combinational BFP16 multiplier.
//   a, b : BFP16 operands
//   p    : BFP16 product (fraction truncated)
// A zero exponent is treated as zero (subnormals flush). Exponent overflow
// saturates to Inf, underflow flushes to signed zero.
// -----------------------------------------------------------------------------
module bfp16_mul
    import bfp16_pkg::*;
(
    input  bfp16_t a,
    input  bfp16_t b,
    output bfp16_t p
);

    logic              a_nan, b_nan, a_zero, b_zero, a_inf, b_inf;
    logic              sign_x;
    logic [8:0]        mant_hi;
    logic signed [9:0] exp_sum;
    logic [6:0]        frac_n;

    always_comb begin
        a_nan  = (a.exp == BFP16_EXP_MAX) && (a.frac != 7'd0);
        b_nan  = (b.exp == BFP16_EXP_MAX) && (b.frac != 7'd0);
        a_inf  = (a.exp == BFP16_EXP_MAX) && (a.frac == 7'd0);
        b_inf  = (b.exp == BFP16_EXP_MAX) && (b.frac == 7'd0);
        a_zero = (a.exp == 8'd0);
        b_zero = (b.exp == 8'd0);
        sign_x = a.sign ^ b.sign;

        // Upper 9 bits of the 8x8 significand product: bit 8 set means the
        // product lies in [2,4) and needs a one-place normalising shift.
        mant_hi = 9'((16'({1'b1, a.frac}) * 16'({1'b1, b.frac})) >> 7);
        frac_n  = mant_hi[8] ? mant_hi[7:1] : mant_hi[6:0];
        exp_sum = 10'(a.exp) + 10'(b.exp) - 10'(BFP16_EXP_BIAS)
                  + (mant_hi[8] ? 10'sd1 : 10'sd0);

        if (a_nan) begin
            p = a;
        end else if (b_nan) begin
            p = b;
        end else if (a_zero || b_zero) begin
            p = '{sign: sign_x, exp: 8'd0, frac: 7'd0};
        end else if (a_inf || b_inf) begin
            p = '{sign: a.sign, exp: BFP16_EXP_MAX, frac: 7'd0};
        end else if (exp_sum >= 10'sd255) begin
            p = '{sign: sign_x, exp: BFP16_EXP_MAX, frac: 7'd0};
        end else if (exp_sum <= 10'sd0) begin
            p = '{sign: sign_x, exp: 8'd0, frac: 7'd0};
        end else begin
            p = '{sign: sign_x, exp: exp_sum[7:0], frac: frac_n};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter.
//   req : request vector (N bits)
//   ptr : index where the priority search starts
//   en  : grant enable; no grant is issued while low
//   gnt : one-hot grant (or zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    logic found;

    // Walk N positions starting at ptr (wrapping) and grant the first request.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (en && !found && req[j] && (j == ((int'(ptr) + k) % N))) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bfp16_mul_arb.sv
// -----------------------------------------------------------------------------
// bfp16_mul_arb
// NREQ requesters share one BFP16 multiplier through a round-robin arbiter.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : bfp16_mul_arb_if.slave (request and response handshakes)
//   busy : high while any pipeline stage holds a valid entry
// Build option: define BFP16_MUL_ARB_OUTREG_EN to add a registered result
// stage S2 (latency 2); otherwise the response comes straight from S1 through
// the multiplier (latency 1).
// -----------------------------------------------------------------------------
module bfp16_mul_arb
    import bfp16_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    bfp16_mul_arb_if.slave       bus,
    output logic                 busy
);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] gnt;
    logic            accept;
    logic            adv;
    logic            out_valid;
    logic [IDW-1:0]  gnt_id;
    bfp16_t          gnt_a, gnt_b;

    logic            s1_valid;
    logic [IDW-1:0]  s1_id;
    bfp16_t          s1_a, s1_b;
    bfp16_t          prod;

    // The whole pipeline moves as one unit: it advances whenever the output
    // is empty or being consumed, and a stalled output blocks new accepts.
    assign adv    = !rst && (!out_valid || bus.rsp_ready);
    assign accept = |gnt;
    assign bus.req_ready = gnt;

    rr_arbiter #(.N(NREQ), .PW(IDW)) u_arb (
        .req (bus.req_valid),
        .ptr (ptr),
        .en  (adv),
        .gnt (gnt)
    );

    // Encode the one-hot grant and select the winner's operands.
    always_comb begin
        gnt_id = '0;
        gnt_a  = '0;
        gnt_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_id = IDW'(i);
                gnt_a  = bus.req_a[i];
                gnt_b  = bus.req_b[i];
            end
        end
    end

    // Pointer moves just past the last winner; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_id <= gnt_id;
                s1_a  <= gnt_a;
                s1_b  <= gnt_b;
            end
        end
    end

    bfp16_mul u_mul (
        .a (s1_a),
        .b (s1_b),
        .p (prod)
    );

`ifdef BFP16_MUL_ARB_OUTREG_EN
    logic           s2_valid;
    logic [IDW-1:0] s2_id;
    bfp16_t         s2_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_data  <= BFP16_ZERO;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_id   <= s1_id;
                s2_data <= prod;
            end
        end
    end

    assign out_valid    = s2_valid;
    assign bus.rsp_id   = s2_id;
    assign bus.rsp_data = s2_data;
    assign busy         = s1_valid | s2_valid;
`else
    assign out_valid    = s1_valid;
    assign bus.rsp_id   = s1_id;
    assign bus.rsp_data = prod;
    assign busy         = s1_valid;
`endif

    assign bus.rsp_valid = out_valid;

endmodule

// File: tb/tb_bfp16_mul_arb.sv
// -----------------------------------------------------------------------------
// tb_bfp16_mul_arb
// Self-checking bench for bfp16_mul_arb: directed operand table, then
// back-pressure, reset mid-flight and 4-way contention sequences.
// Follows BFP16_MUL_ARB_OUTREG_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_bfp16_mul_arb;

    localparam int NREQ = 4;
`ifdef BFP16_MUL_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[12];

    always #5 clk = ~clk;

    bfp16_mul_arb_if #(.NREQ(NREQ)) bus ();

    bfp16_mul_arb #(.NREQ(NREQ)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp_v);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timed out", name);
    endtask

    // Offer one operand pair from requester idx, wait for its accept, then
    // count negedges until the product shows up on the response side.
    task automatic apply_stimulus(input logic [1:0] idx, input logic [15:0] a, input logic [15:0] b,
                                  output int lat, output bit ok);
        int n;
        ok  = 1'b0;
        lat = 0;
        @(negedge clk);
        bus.req_valid[idx] = 1'b1;
        bus.req_a[idx]     = a;
        bus.req_b[idx]     = b;
        #1;
        n = 0;
        while (!bus.req_ready[idx] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.req_ready[idx]) begin
            bus.req_valid[idx] = 1'b0;
            report_timeout("accept");
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid[idx] = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        if (!bus.rsp_valid) report_timeout("response");
        else ok = 1'b1;
    endtask

    initial begin
        int  lat;
        bit  ok;

        vecs[0]  = '{2'd0, 16'h3F80, 16'h4000, 16'h4000};
        vecs[1]  = '{2'd1, 16'h7FC0, 16'h3F80, 16'h7FC0};
        vecs[2]  = '{2'd2, 16'h0000, 16'h4000, 16'h0000};
        vecs[3]  = '{2'd3, 16'hBF80, 16'h3F80, 16'hBF80};
        vecs[4]  = '{2'd0, 16'h7F80, 16'h3F80, 16'h7F80};
        vecs[5]  = '{2'd1, 16'h3FC0, 16'h3FC0, 16'h4010};
        vecs[6]  = '{2'd2, 16'h8000, 16'h4000, 16'h8000};
        vecs[7]  = '{2'd3, 16'h4000, 16'h7FC1, 16'h7FC1};
        vecs[8]  = '{2'd0, 16'hFF80, 16'h4000, 16'hFF80};
        vecs[9]  = '{2'd1, 16'h4040, 16'h4000, 16'h40C0};
        vecs[10] = '{2'd3, 16'hC040, 16'hC000, 16'h40C0};
        vecs[11] = '{2'd2, 16'h3F80, 16'h3F80, 16'h3F80};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, with every requester asking so req_ready gating shows.
        repeat (2) @(negedge clk);
        bus.req_valid = '1;
        #1;
        check_output("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_output("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
        check_output("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
        check_output("rst_busy",      32'(busy),          32'h0);
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // Directed operand table.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].idx, vecs[i].a, vecs[i].b, lat, ok);
            if (ok) begin
                check_output($sformatf("vec%0d_latency", i), 32'(lat),          32'(LAT));
                check_output($sformatf("vec%0d_id", i),      32'(bus.rsp_id),   32'(vecs[i].idx));
                check_output($sformatf("vec%0d_data", i),    32'(bus.rsp_data), 32'(vecs[i].exp_data));
            end
        end
        @(negedge clk);
        check_output("drain_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_output("drain_busy",      32'(busy),          32'h0);

        // Back-pressure: product must hold steady and no accepts happen.
        bus.rsp_ready = 1'b0;
        apply_stimulus(2'd1, 16'h3FC0, 16'h3FC0, lat, ok);
        if (ok) begin
            bus.req_a     = {4{16'h3F80}};
            bus.req_b     = {4{16'h3F80}};
            bus.req_valid = '1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                #1;
                check_output($sformatf("bp%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'h1);
                check_output($sformatf("bp%0d_rsp_id", k),    32'(bus.rsp_id),    32'h1);
                check_output($sformatf("bp%0d_rsp_data", k),  32'(bus.rsp_data),  32'h4010);
                check_output($sformatf("bp%0d_req_ready", k), 32'(bus.req_ready), 32'h0);
            end
            bus.req_valid = '0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_output("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_output("bp_release_busy",      32'(busy),          32'h0);

        // Reset with the pipeline full and stalled.
        bus.rsp_ready = 1'b0;
        bus.req_a     = {4{16'h3F80}};
        bus.req_b     = {4{16'h4000}};
        bus.req_valid = '1;
        repeat (3) @(negedge clk);
        check_output("mid_busy_before", 32'(busy), 32'h1);
        bus.req_valid = '0;
        rst           = 1'b1;
        @(negedge clk);
        check_output("mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_output("mid_busy",      32'(busy),          32'h0);
        check_output("mid_rsp_data",  32'(bus.rsp_data),  32'h0);
        check_output("mid_rsp_id",    32'(bus.rsp_id),    32'h0);
        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output($sformatf("stale%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'h0);
        end

        // Contention right after reset: grants start at 0 and rotate.
        bus.req_a     = {4{16'h4040}};
        bus.req_b     = {4{16'h4000}};
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check_output($sformatf("rr%0d_req_ready", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
            if (k >= LAT) begin
                check_output($sformatf("rr%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'h1);
                check_output($sformatf("rr%0d_rsp_id", k),    32'(bus.rsp_id),    32'((k - LAT) % 4));
                check_output($sformatf("rr%0d_rsp_data", k),  32'(bus.rsp_data),  32'h40C0);
            end
        end
        bus.req_valid = '0;
        repeat (LAT + 1) @(negedge clk);
        check_output("rr_drain_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bfp16_mul_arb.md
BFP16_MUL_ARB -- requirements
Module: bfp16_mul_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one BFP16 multiplier (2..8).
REQ-002 Parameter IDW, default $clog2(NREQ): width of the requester ID.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester operand-pair valid.
REQ-006 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 req_a  input  NREQx16  per-requester BFP16 operand A (1 sign, 8 exponent, 7 fraction).
REQ-008 req_b  input  NREQx16  per-requester BFP16 operand B.
REQ-009 rsp_valid  output  1  product valid.
REQ-010 rsp_ready  input  1  consumer accepts product.
REQ-011 rsp_id  output  IDW  index of the requester that owns rsp_data.
REQ-012 rsp_data  output  16  BFP16 product.
REQ-013 busy  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-014 A request transfers on cycle t when req_valid[i] and req_ready[i] are both high at the rising edge.
REQ-015 req_ready[i] is high only when i is the round-robin winner among asserted req_valid bits and stage S1 is empty or draining this cycle.
REQ-016 Round-robin: search starts at pointer P; after a grant to i, P becomes (i+1) mod NREQ; with no grant, P holds.
REQ-017 req_ready is a function of req_valid, P and pipeline state only; it never depends on req_a or req_b.
REQ-018 Stage S1 registers {valid, id, a, b} on accept; the single multiplier instance reads S1 combinationally.
REQ-019 Multiplier semantics:
  - NaN operand (exp 255, fraction nonzero) returns that operand, A checked first.
  - Zero operand returns sign(A)^sign(B) with exp 0, fraction 0.
  - Inf returns sign(A), exp 255, fraction 0.
  - Otherwise: sign XOR, exponent sum minus 127, 8x8 mantissa product normalised, fraction truncated.
REQ-020 Latency: rsp_valid rises 1 cycle after accept (macro off) or 2 cycles after accept (macro on).
REQ-021 rsp_valid stays high and rsp_id/rsp_data stay stable until rsp_ready is sampled high.
REQ-022 Back-pressure: with rsp_valid high and rsp_ready low, the pipeline does not advance and all req_ready bits are low.
REQ-023 Simultaneous response handshake and new accept in one cycle is allowed; sustained throughput is 1 product per cycle.
REQ-024 Responses leave in accept order; no reordering.
REQ-025 A requester deasserting req_valid before ready is not an error; P does not move.

Reset
REQ-026 On rst: S1/S2 valid=0, P=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0x0000, busy=0.
REQ-027 rst mid-operation discards all in-flight products; no response for them is ever emitted.

Configuration
REQ-028 Macro BFP16_MUL_ARB_OUTREG_EN defined: result stage S2 registers {valid, id, product} after the multiplier; rsp_* driven from S2; latency 2.
REQ-029 Macro undefined: rsp_* driven combinationally from S1 through the multiplier; latency 1; no S2 flops.

Structure
REQ-030 Shared package bfp16_pkg holds typedef bfp16_t (16-bit packed sign/exp/frac), constants BFP16_EXP_BIAS=127, BFP16_EXP_MAX=255, BFP16_ZERO=16'h0000.
REQ-031 Sub-module rr_arbiter (parameter N; inputs req, ptr, en; output one-hot gnt) implements REQ-015/016; the multiplier is one separate instance.

Verification
REQ-032 Single: req 0 sends a=0x3F80, b=0x4000 -> rsp_data=0x4000, rsp_id=0 after configured latency.
REQ-033 Contention: all 4 req_valid high continuously, a=0x4040, b=0x4000 -> grants 0,1,2,3,0 on consecutive cycles; each rsp_data=0x40C0.
REQ-034 Back-pressure: rsp_ready low 5 cycles with rsp pending -> rsp_valid, rsp_id, rsp_data stable; req_ready all 0; no product lost.
REQ-035 Corners: 0x7FC0*0x3F80 -> 0x7FC0; 0x0000*0x4000 -> 0x0000; 0xBF80*0x3F80 -> 0xBF80; 0x7F80*0x3F80 -> 0x7F80.
REQ-036 Reset mid-flight: assert rst with S1 (and S2) full -> next cycle rsp_valid=0, busy=0, P=0; no stale response afterwards.
